// File: rtl/id_issue_stage_pkg.sv
// id_issue_stage_pkg: shared constants and helpers for the issue stage
package id_issue_stage_pkg;
  localparam logic RstEnable = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic [4:0] NOPRegAddr = 5'b0;
  localparam logic [7:0] EXE_NOP_OP = 8'b0;
  localparam logic [2:0] EXE_RES_NOP = 3'b0;
  function automatic int cnt_w(int lat);
    return $clog2(lat + 1);
  endfunction
endpackage

// File: rtl/id_issue_stage_if.sv
// id_issue_stage_if: ID/EX output bundle with valid/ready handshake
interface id_issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ALUOP_W = 8,
  parameter int ALUSEL_W = 3
);
  logic out_valid;
  logic out_ready;
  logic [ALUOP_W-1:0] aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [ADDR_W-1:0] wd_o;
  logic wreg_o;
  logic load_o;
  modport master(output out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, load_o, input out_ready);
  modport slave(input out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, load_o, output out_ready);
endinterface

// File: rtl/id_operand_mux.sv
// id_operand_mux: operand select among immediate, zero register, forwarding ports (port 0 first) and register file
module id_operand_mux
  import id_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [FWD_PORTS-1:0] fwd_wreg,
  input  logic [FWD_PORTS*ADDR_W-1:0] fwd_wd,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_wdata,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] src;
  always_comb begin
    src = rf_data;
    for (int k = FWD_PORTS - 1; k >= 0; k--)
      if (fwd_wreg[k] && fwd_wd[k*ADDR_W +: ADDR_W] == addr) src = fwd_wdata[k*DATA_W +: DATA_W];
  end
  assign data = !read ? imm : (addr == '0) ? DATA_W'(ZeroWord) : src;
endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage: registered issue stage with operand forwarding and load-use scoreboard
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FWD_PORTS = 2,
  parameter int LOAD_LAT = 1,
  parameter int ALUOP_W = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic reg1_read_i,
  input  logic reg2_read_i,
  input  logic [ADDR_W-1:0] reg1_addr_i,
  input  logic [ADDR_W-1:0] reg2_addr_i,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic wreg_i,
  input  logic load_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [FWD_PORTS-1:0] fwd_wreg_i,
  input  logic [FWD_PORTS*ADDR_W-1:0] fwd_wd_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_wdata_i,
  input  logic flush_i,
  output logic stallreq_o,
  id_issue_stage_if.master ex
);
  localparam int CW = cnt_w(LOAD_LAT);
  localparam int NREG = 2 ** ADDR_W;
  logic [CW-1:0] cnt [NREG];
  logic [DATA_W-1:0] op1, op2;
  logic pend, retire, haz1, haz2, hazard;
  assign pend = ex.out_valid & ex.load_o & ex.wreg_o;
  assign retire = pend & ex.out_ready & (ex.wd_o != ADDR_W'(NOPRegAddr));
  assign haz1 = reg1_read_i & (reg1_addr_i != '0) & ((cnt[reg1_addr_i] != '0) | (pend & (ex.wd_o == reg1_addr_i)));
  assign haz2 = reg2_read_i & (reg2_addr_i != '0) & ((cnt[reg2_addr_i] != '0) | (pend & (ex.wd_o == reg2_addr_i)));
  assign hazard = haz1 | haz2;
  assign stallreq_o = in_valid & hazard;
  assign in_ready = !flush_i & !hazard & (!ex.out_valid | ex.out_ready);
  id_operand_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_PORTS(FWD_PORTS)) u_op1 (
    .read(reg1_read_i), .addr(reg1_addr_i), .rf_data(reg1_data_i), .imm(imm_i),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .data(op1)
  );
  id_operand_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_PORTS(FWD_PORTS)) u_op2 (
    .read(reg2_read_i), .addr(reg2_addr_i), .rf_data(reg2_data_i), .imm(imm_i),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .data(op2)
  );
  // a retiring load reloads its counter even if that counter is still draining
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable)
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    else
      for (int i = 0; i < NREG; i++)
        cnt[i] <= (retire && ex.wd_o == ADDR_W'(i)) ? CW'(LOAD_LAT) : (cnt[i] != '0) ? cnt[i] - CW'(1) : cnt[i];
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) begin
      ex.out_valid <= 1'b0;
      ex.aluop_o <= ALUOP_W'(EXE_NOP_OP);
      ex.alusel_o <= ALUSEL_W'(EXE_RES_NOP);
      ex.reg1_o <= DATA_W'(ZeroWord);
      ex.reg2_o <= DATA_W'(ZeroWord);
      ex.wd_o <= ADDR_W'(NOPRegAddr);
      ex.wreg_o <= 1'b0;
      ex.load_o <= 1'b0;
    end else if (flush_i)
      ex.out_valid <= 1'b0;
    else if (in_valid && in_ready) begin
      ex.out_valid <= 1'b1;
      ex.aluop_o <= aluop_i;
      ex.alusel_o <= alusel_i;
      ex.reg1_o <= op1;
      ex.reg2_o <= op2;
      ex.wd_o <= wd_i;
      ex.wreg_o <= wreg_i;
      ex.load_o <= load_i;
    end else if (ex.out_ready)
      ex.out_valid <= 1'b0;
endmodule

// File: tb/tb_id_issue_stage.sv
// tb_id_issue_stage: directed and randomized checks against a cycle-level reference model
module tb_id_issue_stage;
  localparam int DW = 32, AW = 5, FP = 2, LL = 1, OW = 8, SW = 3;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid, in_ready, r1rd, r2rd, wreg, load, flush, stall;
  logic [AW-1:0] r1a, r2a, wd;
  logic [DW-1:0] r1d, r2d, imm;
  logic [OW-1:0] aluop;
  logic [SW-1:0] alusel;
  logic [FP-1:0] fwreg;
  logic [FP*AW-1:0] fwd;
  logic [FP*DW-1:0] fdata;
  id_issue_stage_if #(.DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .ALUSEL_W(SW)) ex();
  id_issue_stage #(.DATA_W(DW), .ADDR_W(AW), .FWD_PORTS(FP), .LOAD_LAT(LL), .ALUOP_W(OW), .ALUSEL_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .reg1_read_i(r1rd), .reg2_read_i(r2rd), .reg1_addr_i(r1a), .reg2_addr_i(r2a),
    .reg1_data_i(r1d), .reg2_data_i(r2d), .imm_i(imm), .wd_i(wd), .wreg_i(wreg), .load_i(load),
    .aluop_i(aluop), .alusel_i(alusel), .fwd_wreg_i(fwreg), .fwd_wd_i(fwd), .fwd_wdata_i(fdata),
    .flush_i(flush), .stallreq_o(stall), .ex(ex)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  int busy [2**AW];
  logic m_v, m_wreg, m_load, last_stall, last_rdy;
  logic [OW-1:0] m_aluop;
  logic [SW-1:0] m_alusel;
  logic [DW-1:0] m_r1, m_r2;
  logic [AW-1:0] m_wd;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] opnd(logic rd, logic [AW-1:0] a, logic [DW-1:0] rf);
    if (!rd) return imm;
    if (a == '0) return '0;
    for (int k = 0; k < FP; k++)
      if (fwreg[k] && fwd[k*AW +: AW] == a) return fdata[k*DW +: DW];
    return rf;
  endfunction
  // a source waits while a load to it sits in the output register or its data is not yet forwardable
  function automatic logic waits(logic rd, logic [AW-1:0] a);
    return rd && a != '0 && (cyc <= busy[a] || (m_v && m_load && m_wreg && m_wd == a));
  endfunction
  task automatic model_reset();
    foreach (busy[i]) busy[i] = -1;
    {m_v, m_wreg, m_load, m_aluop, m_alusel, m_r1, m_r2, m_wd} = '0;
  endtask
  task automatic check_out(string t);
    chk({t, ".valid"}, 64'(ex.out_valid), 64'(m_v));
    chk({t, ".aluop"}, 64'(ex.aluop_o), 64'(m_aluop));
    chk({t, ".alusel"}, 64'(ex.alusel_o), 64'(m_alusel));
    chk({t, ".reg1"}, 64'(ex.reg1_o), 64'(m_r1));
    chk({t, ".reg2"}, 64'(ex.reg2_o), 64'(m_r2));
    chk({t, ".wd"}, 64'(ex.wd_o), 64'(m_wd));
    chk({t, ".wreg"}, 64'(ex.wreg_o), 64'(m_wreg));
    chk({t, ".load"}, 64'(ex.load_o), 64'(m_load));
  endtask
  task automatic idle();
    {in_valid, r1rd, r2rd, wreg, load, flush} = '0;
    {r1a, r2a, wd, r1d, r2d, imm, aluop, alusel, fwreg, fwd, fdata} = '0;
    ex.out_ready = 1'b1;
  endtask
  task automatic tick();
    logic h, rdy;
    #1;
    h = waits(r1rd, r1a) || waits(r2rd, r2a);
    rdy = !flush && !h && (!m_v || ex.out_ready);
    last_stall = stall;
    last_rdy = in_ready;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("stallreq", 64'(stall), 64'(in_valid && h));
    if (m_v && ex.out_ready && m_load && m_wreg && m_wd != '0) busy[m_wd] = cyc + LL;
    if (flush) m_v = 1'b0;
    else if (in_valid && rdy) begin
      m_v = 1'b1;
      m_aluop = aluop;
      m_alusel = alusel;
      m_r1 = opnd(r1rd, r1a, r1d);
      m_r2 = opnd(r2rd, r2a, r2d);
      m_wd = wd;
      m_wreg = wreg;
      m_load = load;
    end else if (ex.out_ready) m_v = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    check_out("out");
    @(negedge clk);
  endtask
  task automatic issue(logic [AW-1:0] d, logic ld, logic rd1, logic [AW-1:0] a1);
    in_valid = 1'b1; wd = d; wreg = 1'b1; load = ld; r1rd = rd1; r1a = a1; r2rd = 1'b0;
  endtask
  initial begin
    idle();
    model_reset();
    #1;
    check_out("reset");
    chk("reset.stall", 64'(stall), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    // or $3,$1,$2 with both ports forwarding
    in_valid = 1'b1; r1rd = 1'b1; r1a = 5'd1; r2rd = 1'b1; r2a = 5'd2; wd = 5'd3; wreg = 1'b1;
    aluop = 8'h25; alusel = 3'd1; r1d = 32'h1234; r2d = 32'h5678;
    fwreg = 2'b11; fwd = {5'd2, 5'd1}; fdata = {32'h5555, 32'hAAAA0000};
    tick();
    chk("t1.reg1", 64'(ex.reg1_o), 64'hAAAA0000);
    chk("t1.reg2", 64'(ex.reg2_o), 64'h5555);
    chk("t1.wd", 64'(ex.wd_o), 64'd3);
    chk("t1.valid", 64'(ex.out_valid), 64'd1);
    fwd = {5'd1, 5'd1}; fdata = {32'h22, 32'h11};
    tick();
    chk("t2.prio", 64'(ex.reg1_o), 64'h11);
    r2a = 5'd0; fwd = {5'd1, 5'd0}; fdata = {32'h22, 32'hFF};
    tick();
    chk("t2.zero", 64'(ex.reg2_o), 64'h0);
    chk("t2.port1", 64'(ex.reg1_o), 64'h22);
    // load-use with LOAD_LAT=1
    idle();
    issue(5'd4, 1'b1, 1'b0, 5'd0);
    tick();
    issue(5'd5, 1'b0, 1'b1, 5'd4);
    fwreg = 2'b10; fwd = {5'd4, 5'd0}; fdata = {32'hDEAD, 32'h0};
    tick();
    chk("t3.stall1", 64'({last_stall, last_rdy}), 64'b10);
    tick();
    chk("t3.stall2", 64'({last_stall, last_rdy}), 64'b10);
    tick();
    chk("t3.go", 64'({last_stall, last_rdy}), 64'b01);
    chk("t3.data", 64'(ex.reg1_o), 64'hDEAD);
    // backpressure
    idle();
    issue(5'd6, 1'b0, 1'b0, 5'd0);
    ex.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4.blocked", 64'(last_rdy), 64'd0);
      chk("t4.hold", 64'(ex.reg1_o), 64'hDEAD);
    end
    ex.out_ready = 1'b1;
    tick();
    chk("t4.release", 64'(last_rdy), 64'd1);
    chk("t4.wd", 64'(ex.wd_o), 64'd6);
    // flush keeps the scoreboard
    issue(5'd5, 1'b1, 1'b0, 5'd0);
    tick();
    issue(5'd7, 1'b0, 1'b0, 5'd0);
    flush = 1'b1;
    tick();
    chk("t5.noaccept", 64'(last_rdy), 64'd0);
    chk("t5.flushed", 64'(ex.out_valid), 64'd0);
    flush = 1'b0;
    issue(5'd8, 1'b0, 1'b1, 5'd5);
    tick();
    chk("t5.stall", 64'(last_stall), 64'd1);
    tick();
    chk("t5.go", 64'(last_rdy), 64'd1);
    // reset in the middle of a stall
    issue(5'd4, 1'b1, 1'b0, 5'd0);
    tick();
    issue(5'd9, 1'b0, 1'b1, 5'd4);
    tick();
    rst = 1'b0;
    #1;
    model_reset();
    check_out("t6.rst");
    chk("t6.stall", 64'(stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t6.nostall", 64'({last_stall, last_rdy}), 64'b01);
    // random traffic on a small register window to provoke hazards and forwarding
    for (int n = 0; n < 3000; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      r1rd = $urandom_range(0, 3) != 0;
      r2rd = $urandom_range(0, 3) != 0;
      r1a = AW'($urandom_range(0, 7));
      r2a = AW'($urandom_range(0, 7));
      r1d = $urandom;
      r2d = $urandom;
      imm = $urandom;
      wd = AW'($urandom_range(0, 7));
      wreg = $urandom_range(0, 3) != 0;
      load = $urandom_range(0, 2) == 0;
      aluop = OW'($urandom);
      alusel = SW'($urandom);
      fwreg = FP'($urandom);
      fwd = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      fdata = {$urandom, $urandom};
      flush = $urandom_range(0, 9) == 0;
      ex.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
